id_decode_queue: RTL and testbench
==================================

Name: id_decode_queue

Overview:
- Parametrised instruction buffer plus decode-front stage between IF and ID/EX.
- Holds up to DEPTH fetched {instr, pc} pairs with valid/ready handshakes on both sides.
- Tracks the MIPS branch-delay-slot property of each issued instruction.
- Computes pc_plus_8, branch and jump targets, and generalised N-source operand forwarding for Rs/Rt.

Parameters:
DEPTH, 4, queue entries; power of two, 2..16
NUM_FWD, 2, forwarding sources; index 0 has highest priority (youngest producer)
PTR_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
if_valid  input  1  IF offers an entry
if_instr  input  32  fetched instruction
if_pc  input  32  PC of if_instr
if_ready  output  1  queue accepts; equals !full
flush  input  1  discard all entries, clear delay-slot tracking
id_valid  output  1  head entry valid
ex_ready  input  1  ID/EX accepts head
id_instr  output  32  head instruction
id_pc  output  32  head PC
id_pc_plus_8  output  32  id_pc+8
id_branch_addr  output  32  id_pc+4+{sext(instr[15:0]),2'b00}
id_jump_addr  output  32  {(id_pc+4)[31:28],instr[25:0],2'b00}
id_bd  output  1  head is in a branch delay slot
id_is_branch  output  1  head is beq/bne/blez/bgtz/regimm/j/jal/jr/jalr
rf_rs_data  input  32  register file read data, Rs
rf_rt_data  input  32  register file read data, Rt
fwd_data  input  32*NUM_FWD  flattened forwarding values; source i at [32i+31:32i]
fwd_sel_rs  input  NUM_FWD  one-hot-or-multi select for Rs
fwd_sel_rt  input  NUM_FWD  select for Rt
rs_value  output  32  forwarded Rs
rt_value  output  32  forwarded Rt
count  output  PTR_W+1  current occupancy

Behaviour:
- Reset (rst=0, async): wr_ptr=rd_ptr=0, count=0, id_valid=0, id_bd=0, last_issued_branch=0. Entry storage is not reset; data outputs are don't-care while id_valid=0.
- Push: when if_valid && if_ready, write {if_instr, if_pc} at wr_ptr and increment it (wraps modulo DEPTH).
- Pop: when id_valid && ex_ready, increment rd_ptr (wraps).
- Push and pop in the same cycle: count unchanged.
- Full (count==DEPTH): if_ready=0 even if a pop occurs that cycle; no combinational ready-through-pop.
- Empty: id_valid=0. Without ID_BYPASS_EN, head data is registered and minimum IF→ID latency is 1 cycle.
- Delay slot: on each pop, last_issued_branch <= id_is_branch. id_bd = last_issued_branch for the current head. Two consecutive branches give the second id_bd=1.
- Branch decode: opcode 000100, 000101, 000110, 000111, 000001, 000010, 000011; or opcode 000000 with funct 001000/001001.
- Flush: synchronous, highest priority. Pointers and count go to 0, last_issued_branch goes to 0. A same-cycle push is dropped and a same-cycle pop is ignored. The next cycle has id_valid=0.
- Forwarding (combinational): rs_value = fwd_data[i] for the lowest set i in fwd_sel_rs, else rf_rs_data. rt_value is identical in form.
- Arithmetic: all 32-bit adds wrap modulo 2^32; no overflow flag.
- Reset mid-operation: all state is cleared immediately and asynchronously; outputs reflect the empty state before the next edge.

Optional Feature:
- Macro: ID_BYPASS_EN.
- With it defined, when count==0, if_valid=1 and flush=0:
  - id_valid=1 combinationally and the head outputs show if_instr/if_pc.
  - If ex_ready=1 the entry is consumed without being written (count stays 0).
  - Otherwise it is written normally.
- Without it, no combinational path exists from if_* to id_*.

Test Plan:
- Reset, then push instr 0x24080005 at pc 0xBFC00000, ex_ready=1 → next cycle id_valid=1, id_pc_plus_8=0xBFC00008, id_bd=0; count returns to 0 after the pop.
- Push 5 entries with ex_ready=0, DEPTH=4 → if_ready=0 after the 4th, count=4; 5th held by IF; pops return entries in FIFO order across pointer wrap.
- Issue beq 0x1109FFFF at pc 0x80000010, then a nop → beq id_branch_addr=0x80000010, id_is_branch=1; nop id_bd=1; following instruction id_bd=0.
- Queue holds 3 entries, assert flush together with if_valid → next cycle count=0, id_valid=0, pushed entry lost, following instruction id_bd=0.
- fwd_sel_rs=2'b11, fwd_data={0x22222222, 0x11111111}, rf_rs_data=0xDEADBEEF → rs_value=0x11111111; with fwd_sel_rs=0 → rs_value=0xDEADBEEF.
- ID_BYPASS_EN defined, empty queue, if_valid=1, ex_ready=1 → same-cycle id_valid=1, id_instr=if_instr, count stays 0. Undefined: id_valid=0 that cycle, 1 the next.

Source files
------------

// File: rtl/id_decode_queue.sv
// id_decode_queue: IF->ID instruction buffer with delay-slot tracking, target
// computation and N-source operand forwarding. Optional macro: ID_BYPASS_EN.
module id_decode_queue #(
    parameter int DEPTH   = 4,
    parameter int NUM_FWD = 2,
    parameter int PTR_W   = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_valid,
    input  logic [31:0]            if_instr,
    input  logic [31:0]            if_pc,
    output logic                   if_ready,
    input  logic                   flush,
    output logic                   id_valid,
    input  logic                   ex_ready,
    output logic [31:0]            id_instr,
    output logic [31:0]            id_pc,
    output logic [31:0]            id_pc_plus_8,
    output logic [31:0]            id_branch_addr,
    output logic [31:0]            id_jump_addr,
    output logic                   id_bd,
    output logic                   id_is_branch,
    input  logic [31:0]            rf_rs_data,
    input  logic [31:0]            rf_rt_data,
    input  logic [32*NUM_FWD-1:0]  fwd_data,
    input  logic [NUM_FWD-1:0]     fwd_sel_rs,
    input  logic [NUM_FWD-1:0]     fwd_sel_rt,
    output logic [31:0]            rs_value,
    output logic [31:0]            rt_value,
    output logic [PTR_W:0]         count
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [31:0]      instr_mem [DEPTH];
    logic [31:0]      pc_mem    [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count_q;
    logic             last_issued_branch;

    logic full;
    logic empty;
    logic bypass;
    logic push_req;
    logic pop_req;
    logic bypass_consume;
    logic do_push;
    logic do_pop;

    assign full     = (count_q == FULL_COUNT);
    assign empty    = (count_q == '0);
    assign if_ready = !full;
    assign count    = count_q;

`ifdef ID_BYPASS_EN
    assign bypass   = empty && if_valid && !flush;
    assign id_instr = bypass ? if_instr : instr_mem[rd_ptr];
    assign id_pc    = bypass ? if_pc    : pc_mem[rd_ptr];
`else
    assign bypass   = 1'b0;
    assign id_instr = instr_mem[rd_ptr];
    assign id_pc    = pc_mem[rd_ptr];
`endif

    assign id_valid = !empty || bypass;
    assign id_bd    = last_issued_branch;

    assign push_req       = if_valid && if_ready;
    assign pop_req        = id_valid && ex_ready;
    // A bypassed entry that is consumed immediately never touches storage.
    assign bypass_consume = bypass && ex_ready;
    assign do_push        = push_req && !flush && !bypass_consume;
    assign do_pop         = pop_req  && !flush && !bypass_consume;

    always_ff @(posedge clk) begin
        if (do_push) begin
            instr_mem[wr_ptr] <= if_instr;
            pc_mem[wr_ptr]    <= if_pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            count_q            <= '0;
            last_issued_branch <= 1'b0;
        end else if (flush) begin
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            count_q            <= '0;
            last_issued_branch <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
            if (pop_req) begin
                last_issued_branch <= id_is_branch;
            end
        end
    end

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] pc_plus_4;

    assign opcode    = id_instr[31:26];
    assign funct     = id_instr[5:0];
    assign pc_plus_4 = id_pc + 32'd4;

    assign id_pc_plus_8   = id_pc + 32'd8;
    assign id_branch_addr = pc_plus_4 + {{14{id_instr[15]}}, id_instr[15:0], 2'b00};
    assign id_jump_addr   = {pc_plus_4[31:28], id_instr[25:0], 2'b00};

    always_comb begin
        id_is_branch = 1'b0;
        case (opcode)
            6'b000001, 6'b000010, 6'b000011,
            6'b000100, 6'b000101, 6'b000110, 6'b000111: id_is_branch = 1'b1;
            6'b000000: id_is_branch = (funct == 6'b001000) || (funct == 6'b001001);
            default:   id_is_branch = 1'b0;
        endcase
    end

    // Scan from the oldest source down so the lowest selected index wins.
    always_comb begin
        rs_value = rf_rs_data;
        rt_value = rf_rt_data;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_sel_rs[i]) begin
                rs_value = fwd_data[32*i +: 32];
            end
            if (fwd_sel_rt[i]) begin
                rt_value = fwd_data[32*i +: 32];
            end
        end
    end

endmodule

// File: tb/tb_id_decode_queue.sv
// tb_id_decode_queue: directed self-checking bench for id_decode_queue (DEPTH=4, NUM_FWD=2).
`timescale 1ns/1ps
module tb_id_decode_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        flush;
    logic        id_valid;
    logic        ex_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus_8;
    logic [31:0] id_branch_addr;
    logic [31:0] id_jump_addr;
    logic        id_bd;
    logic        id_is_branch;
    logic [31:0] rf_rs_data;
    logic [31:0] rf_rt_data;
    logic [63:0] fwd_data;
    logic [1:0]  fwd_sel_rs;
    logic [1:0]  fwd_sel_rt;
    logic [31:0] rs_value;
    logic [31:0] rt_value;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    id_decode_queue #(.DEPTH(4), .NUM_FWD(2)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
        .flush(flush), .id_valid(id_valid), .ex_ready(ex_ready),
        .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus_8(id_pc_plus_8),
        .id_branch_addr(id_branch_addr), .id_jump_addr(id_jump_addr),
        .id_bd(id_bd), .id_is_branch(id_is_branch),
        .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data), .fwd_data(fwd_data),
        .fwd_sel_rs(fwd_sel_rs), .fwd_sel_rt(fwd_sel_rt),
        .rs_value(rs_value), .rt_value(rt_value), .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] entry(input int k);
        return 32'h2400_0000 | 32'(k);
    endfunction

    task automatic test_reset();
        #3;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", count); end
        n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL reset_id_valid got %b exp 0", id_valid); end
        n_cmp++; if (if_ready !== 1'b1) begin n_err++; $display("FAIL reset_if_ready got %b exp 1", if_ready); end
        n_cmp++; if (id_bd !== 1'b0) begin n_err++; $display("FAIL reset_id_bd got %b exp 0", id_bd); end
        tick();
        rst = 1'b1;
    endtask

    task automatic test_basic();
        if_valid = 1'b1; if_instr = 32'h24080005; if_pc = 32'hBFC00000; ex_ready = 1'b1;
        tick();
        if_valid = 1'b0;
`ifdef ID_BYPASS_EN
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL basic_bypass_count got %0d exp 0", count); end
`else
        n_cmp++; if (id_valid !== 1'b1) begin n_err++; $display("FAIL basic_id_valid got %b exp 1", id_valid); end
        n_cmp++; if (id_instr !== 32'h24080005) begin n_err++; $display("FAIL basic_id_instr got %h exp 24080005", id_instr); end
        n_cmp++; if (id_pc_plus_8 !== 32'hBFC00008) begin n_err++; $display("FAIL basic_pc_plus_8 got %h exp bfc00008", id_pc_plus_8); end
        n_cmp++; if (id_bd !== 1'b0) begin n_err++; $display("FAIL basic_id_bd got %b exp 0", id_bd); end
        n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL basic_count1 got %0d exp 1", count); end
        tick();
`endif
        ex_ready = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL basic_count0 got %0d exp 0", count); end
        n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL basic_empty got %b exp 0", id_valid); end
    endtask

    task automatic test_full_wrap();
        for (int k = 0; k < 4; k++) begin
            if_valid = 1'b1; if_instr = entry(k); if_pc = 32'h100 + 32'(4*k);
            tick();
        end
        if_instr = entry(4); if_pc = 32'h110;
        #1;
        n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL full_count got %0d exp 4", count); end
        n_cmp++; if (if_ready !== 1'b0) begin n_err++; $display("FAIL full_if_ready got %b exp 0", if_ready); end
        tick();
        n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL full_hold got %0d exp 4", count); end
        ex_ready = 1'b1;
        #1;
        n_cmp++; if (if_ready !== 1'b0) begin n_err++; $display("FAIL full_no_ready_through got %b exp 0", if_ready); end
        n_cmp++; if (id_instr !== entry(0)) begin n_err++; $display("FAIL fifo_e0 got %h exp %h", id_instr, entry(0)); end
        tick();
        n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL full_pop_count got %0d exp 3", count); end
        n_cmp++; if (id_instr !== entry(1)) begin n_err++; $display("FAIL fifo_e1 got %h exp %h", id_instr, entry(1)); end
        tick();
        if_valid = 1'b0;
        n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL pushpop_count got %0d exp 3", count); end
        for (int k = 2; k < 5; k++) begin
            n_cmp++; if (id_instr !== entry(k) || id_pc !== 32'h100 + 32'(4*k)) begin
                n_err++; $display("FAIL fifo_e%0d got %h/%h exp %h/%h", k, id_instr, id_pc, entry(k), 32'h100 + 32'(4*k));
            end
            tick();
        end
        ex_ready = 1'b0;
        n_cmp++; if (count !== 3'd0 || id_valid !== 1'b0) begin n_err++; $display("FAIL drain got %0d/%b exp 0/0", count, id_valid); end
    endtask

    task automatic test_branch();
        logic [31:0] ins [4];
        ins[0] = 32'h1109FFFF; ins[1] = 32'h00000000; ins[2] = 32'h24080005; ins[3] = 32'h08000004;
        for (int k = 0; k < 4; k++) begin
            if_valid = 1'b1; if_instr = ins[k]; if_pc = 32'h80000010 + 32'(4*k);
            tick();
        end
        if_valid = 1'b0;
        n_cmp++; if (id_is_branch !== 1'b1) begin n_err++; $display("FAIL beq_is_branch got %b exp 1", id_is_branch); end
        n_cmp++; if (id_branch_addr !== 32'h80000010) begin n_err++; $display("FAIL beq_target got %h exp 80000010", id_branch_addr); end
        n_cmp++; if (id_bd !== 1'b0) begin n_err++; $display("FAIL beq_bd got %b exp 0", id_bd); end
        ex_ready = 1'b1;
        tick();
        n_cmp++; if (id_bd !== 1'b1 || id_is_branch !== 1'b0) begin n_err++; $display("FAIL nop_bd got %b/%b exp 1/0", id_bd, id_is_branch); end
        tick();
        n_cmp++; if (id_bd !== 1'b0) begin n_err++; $display("FAIL after_slot_bd got %b exp 0", id_bd); end
        tick();
        n_cmp++; if (id_jump_addr !== 32'h80000010 || id_is_branch !== 1'b1) begin
            n_err++; $display("FAIL j_target got %h/%b exp 80000010/1", id_jump_addr, id_is_branch);
        end
        tick();
        ex_ready = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL branch_drain got %0d exp 0", count); end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) begin
            if_valid = 1'b1; if_instr = entry(10 + k); if_pc = 32'h200 + 32'(4*k);
            tick();
        end
        n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL pre_flush_count got %0d exp 3", count); end
        flush = 1'b1; if_instr = 32'h2400BEEF;
        tick();
        flush = 1'b0; if_valid = 1'b0;
        n_cmp++; if (count !== 3'd0 || id_valid !== 1'b0) begin n_err++; $display("FAIL flush_state got %0d/%b exp 0/0", count, id_valid); end
        if_valid = 1'b1; if_instr = 32'h24080005; if_pc = 32'h300;
        tick();
        if_valid = 1'b0;
        n_cmp++; if (id_bd !== 1'b0 || id_instr !== 32'h24080005) begin
            n_err++; $display("FAIL post_flush got bd=%b %h exp bd=0 24080005", id_bd, id_instr);
        end
        ex_ready = 1'b1;
        tick();
        ex_ready = 1'b0;
    endtask

    task automatic test_forwarding();
        fwd_data = {32'h22222222, 32'h11111111};
        rf_rs_data = 32'hDEADBEEF; rf_rt_data = 32'hCAFEF00D;
        fwd_sel_rs = 2'b11; fwd_sel_rt = 2'b10;
        #1;
        n_cmp++; if (rs_value !== 32'h11111111) begin n_err++; $display("FAIL fwd_rs_prio got %h exp 11111111", rs_value); end
        n_cmp++; if (rt_value !== 32'h22222222) begin n_err++; $display("FAIL fwd_rt_src1 got %h exp 22222222", rt_value); end
        fwd_sel_rs = 2'b00; fwd_sel_rt = 2'b00;
        #1;
        n_cmp++; if (rs_value !== 32'hDEADBEEF) begin n_err++; $display("FAIL fwd_rs_rf got %h exp deadbeef", rs_value); end
        n_cmp++; if (rt_value !== 32'hCAFEF00D) begin n_err++; $display("FAIL fwd_rt_rf got %h exp cafef00d", rt_value); end
    endtask

    task automatic test_bypass();
        if_valid = 1'b1; if_instr = 32'h24090007; if_pc = 32'h400; ex_ready = 1'b1;
        #1;
`ifdef ID_BYPASS_EN
        n_cmp++; if (id_valid !== 1'b1 || id_instr !== 32'h24090007) begin
            n_err++; $display("FAIL bypass_same_cycle got %b/%h exp 1/24090007", id_valid, id_instr);
        end
        tick();
        if_valid = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL bypass_count got %0d exp 0", count); end
`else
        n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL nobypass_same_cycle got %b exp 0", id_valid); end
        tick();
        if_valid = 1'b0;
        n_cmp++; if (id_valid !== 1'b1 || id_instr !== 32'h24090007) begin
            n_err++; $display("FAIL nobypass_next got %b/%h exp 1/24090007", id_valid, id_instr);
        end
        tick();
`endif
        ex_ready = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL bypass_drain got %0d exp 0", count); end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 2; k++) begin
            if_valid = 1'b1; if_instr = entry(20 + k); if_pc = 32'h500 + 32'(4*k);
            tick();
        end
        if_valid = 1'b0;
        n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL pre_reset_count got %0d exp 2", count); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd0 || id_valid !== 1'b0 || if_ready !== 1'b1) begin
            n_err++; $display("FAIL async_reset got %0d/%b/%b exp 0/0/1", count, id_valid, if_ready);
        end
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0; flush = 1'b0; ex_ready = 1'b0;
        rf_rs_data = '0; rf_rt_data = '0; fwd_data = '0; fwd_sel_rs = '0; fwd_sel_rt = '0;
        test_reset();
        test_basic();
        test_full_wrap();
        test_branch();
        test_flush();
        test_forwarding();
        test_bypass();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
